sme_wild: RTL

SME_WILD -- requirements
Module: sme_wild

---
 rtl/sme_wild.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/sme_wild.sv
// Wildcard string matcher: stores one string and one pattern, then scans candidate start
// positions serially, with '^' '$' '.' '*' meta characters and a single honoured '*'.
module sme_wild #(
  parameter int unsigned STR_DEPTH = 32,
  parameter int unsigned PAT_DEPTH = 8,
  parameter int unsigned IDX_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index,
  output logic             busy
);

  // Position counters must reach STR_DEPTH+1 to detect running off the end.
  localparam int unsigned SLW = $clog2(STR_DEPTH + 2);
  localparam int unsigned PLW = $clog2(PAT_DEPTH + 1);
  localparam int unsigned SAW = (STR_DEPTH > 1) ? $clog2(STR_DEPTH) : 1;
  localparam int unsigned PAW = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StPre, StSuf, StDone} state_e;

  state_e             state_q, state_d;
  logic [SLW-1:0]     p_q, p_d, q_q, q_d;
  logic               match_q, match_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SLW-1:0]     str_len_q, str_len_d;
  logic [PLW-1:0]     pat_len_q, pat_len_d;
  logic               str_prev_q, pat_prev_q;
  logic               str_load_q, str_load_d, pat_load_q, pat_load_d;
  logic [7:0]         str_mem_q [STR_DEPTH];
  logic [7:0]         pat_mem_q [PAT_DEPTH];

  logic               idle, str_act, pat_act, start;
  logic [SLW-1:0]     str_base;
  logic [PLW-1:0]     pat_base;
  logic               str_we, pat_we;
  logic [SAW-1:0]     str_wa;
  logic [PAW-1:0]     pat_wa;

  assign idle = (state_q == StIdle);

  always_comb begin
    str_act    = idle & isstring & ((isstring & ~str_prev_q) | str_load_q);
    pat_act    = idle & ispattern & ((ispattern & ~pat_prev_q) | pat_load_q);
    str_load_d = str_act;
    pat_load_d = pat_act;
    start      = idle & pat_load_q & ~ispattern;
    str_base   = (isstring & ~str_prev_q) ? '0 : str_len_q;
    pat_base   = (ispattern & ~pat_prev_q) ? '0 : pat_len_q;
    str_we     = 1'b0;
    pat_we     = 1'b0;
    str_wa     = str_base[SAW-1:0];
    pat_wa     = pat_base[PAW-1:0];
    str_len_d  = str_len_q;
    pat_len_d  = pat_len_q;
    if (str_act) begin
      str_len_d = str_base;
      if (int'(str_base) < int'(STR_DEPTH)) begin
        str_we    = 1'b1;
        str_len_d = str_base + SLW'(1);
      end
    end
    if (pat_act) begin
      pat_len_d = pat_base;
      if (int'(pat_base) < int'(PAT_DEPTH)) begin
        pat_we    = 1'b1;
        pat_len_d = pat_base + PLW'(1);
      end
    end
  end

  logic caret, dollar, has_star, pre_hit, suf_hit;
  int   slen, plen, first, lidx, last, star, pre_len, suf_len, p, q, pos;

  always_comb begin
    slen     = int'(str_len_q);
    plen     = int'(pat_len_q);
    p        = int'(p_q);
    q        = int'(q_q);
    pos      = 0;
    caret    = (plen > 0) && (pat_mem_q[0] == 8'h5E);
    first    = caret ? 1 : 0;
    lidx     = plen - 1;
    dollar   = (plen > first) && (pat_mem_q[lidx[PAW-1:0]] == 8'h24);
    last     = dollar ? plen - 1 : plen;
    has_star = 1'b0;
    star     = last;
    for (int i = 0; i < int'(PAT_DEPTH); i++) begin
      if (!has_star && i >= first && i < last && pat_mem_q[i] == 8'h2A) begin
        has_star = 1'b1;
        star     = i;
      end
    end
    pre_len = star - first;
    suf_len = has_star ? last - star - 1 : 0;

    pre_hit = 1'b1;
    if (caret && p != 0) begin
      pos = p - 1;
      if (pos >= slen || str_mem_q[pos[SAW-1:0]] != 8'h20) pre_hit = 1'b0;
    end
    for (int i = 0; i < int'(PAT_DEPTH); i++) begin
      if (i >= first && i < star) begin
        pos = p + i - first;
        if (pos >= slen) pre_hit = 1'b0;
        else if (pat_mem_q[i] != 8'h2E && str_mem_q[pos[SAW-1:0]] != pat_mem_q[i]) begin
          pre_hit = 1'b0;
        end
      end
    end
    if (dollar && !has_star) begin
      pos = p + pre_len;
      if (!(pos == slen || (pos < slen && str_mem_q[pos[SAW-1:0]] == 8'h20))) pre_hit = 1'b0;
    end

    // A second '*' inside the suffix acts as a single-character wildcard.
    suf_hit = 1'b1;
    for (int i = 0; i < int'(PAT_DEPTH); i++) begin
      if (has_star && i > star && i < last) begin
        pos = q + i - star - 1;
        if (pos >= slen) suf_hit = 1'b0;
        else if (pat_mem_q[i] != 8'h2E && pat_mem_q[i] != 8'h2A &&
                 str_mem_q[pos[SAW-1:0]] != pat_mem_q[i]) begin
          suf_hit = 1'b0;
        end
      end
    end
    if (dollar) begin
      pos = q + suf_len;
      if (!(pos == slen || (pos < slen && str_mem_q[pos[SAW-1:0]] == 8'h20))) suf_hit = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    match_d = match_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPre;
          p_d     = '0;
        end
      end
      StPre: begin
        if (p > slen) begin
          state_d = StDone;
          match_d = 1'b0;
          idx_d   = '0;
        end else if (pre_hit) begin
          if (has_star) begin
            state_d = StSuf;
            q_d     = SLW'(p + pre_len);
          end else begin
            state_d = StDone;
            match_d = 1'b1;
            idx_d   = IDX_W'(p);
          end
        end else begin
          p_d = p_q + SLW'(1);
        end
      end
      StSuf: begin
        if (q > slen) begin
          state_d = StPre;
          p_d     = p_q + SLW'(1);
        end else if (suf_hit) begin
          state_d = StDone;
          match_d = 1'b1;
          idx_d   = IDX_W'(p);
        end else begin
          q_d = q_q + SLW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      p_q        <= '0;
      q_q        <= '0;
      match_q    <= 1'b0;
      idx_q      <= '0;
      str_len_q  <= '0;
      pat_len_q  <= '0;
      str_prev_q <= 1'b0;
      pat_prev_q <= 1'b0;
      str_load_q <= 1'b0;
      pat_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      q_q        <= q_d;
      match_q    <= match_d;
      idx_q      <= idx_d;
      str_len_q  <= str_len_d;
      pat_len_q  <= pat_len_d;
      str_prev_q <= isstring;
      pat_prev_q <= ispattern;
      str_load_q <= str_load_d;
      pat_load_q <= pat_load_d;
    end
  end

  always_ff @(posedge clk) begin
    if (str_we) str_mem_q[str_wa] <= chardata;
    if (pat_we) pat_mem_q[pat_wa] <= chardata;
  end

  assign valid       = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign match       = match_q;
  assign match_index = idx_q;

endmodule
